// File: rtl/fwd_hazard_unit.sv
// Operand forwarding (MEM > WB > LATE > RF) and load-use stall/bubble control
// for the 5-stage pipeline, with saturating stall/forward event counters.
module fwd_hazard_unit #(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned PC_INC      = 1,
  parameter int unsigned LATE_BYPASS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_ra,
  input  logic [AW-1:0]    id_rb,
  input  logic [AW-1:0]    ex_ra,
  input  logic [AW-1:0]    ex_rb,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [AW-1:0]    ex_dst,
  input  logic [DW-1:0]    rf_a,
  input  logic [DW-1:0]    rf_b,
  input  logic [DW-1:0]    ext,
  input  logic             alusrc,
  input  logic             memwrite,
  input  logic             mem_regwrite,
  input  logic [AW-1:0]    mem_dst,
  input  logic [1:0]       mem_sel,
  input  logic [DW-1:0]    mem_alu,
  input  logic [DW-1:0]    mem_imm,
  input  logic [DW-1:0]    mem_pc,
  input  logic             wb_regwrite,
  input  logic [AW-1:0]    wb_dst,
  input  logic [1:0]       wb_sel,
  input  logic [DW-1:0]    wb_alu,
  input  logic [DW-1:0]    wb_imm,
  input  logic [DW-1:0]    wb_pc,
  input  logic [DW-1:0]    wb_ram,
  output logic [DW-1:0]    x,
  output logic [DW-1:0]    y,
  output logic [DW-1:0]    mem_din,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] fwd_count
);

  localparam int unsigned CW         = 2;
  localparam bit          MULTI_LAT  = (LOAD_LAT > 1);
  localparam logic [CW-1:0] WAIT_INIT = CW'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
  localparam logic [DW-1:0] PC_STEP  = DW'(PC_INC);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  mem_res, wb_res;
  logic           late_valid;
  logic [AW-1:0]  late_dst;
  logic [DW-1:0]  late_res;
  logic [DW-1:0]  fwd_a, fwd_b;
  logic           hit_a, hit_b;
  logic           hz, fwd_evt;

  function automatic logic stage_hit(input logic we, input logic [AW-1:0] dst,
                                     input logic [AW-1:0] src);
    return we && (dst == src) && (src != '0);
  endfunction

  // Stage result muxes; reserved MEM select falls back to the ALU value.
  always_comb begin
    mem_res = mem_alu;
    case (mem_sel)
      2'd1:    mem_res = mem_imm;
      2'd2:    mem_res = mem_pc + PC_STEP;
      default: mem_res = mem_alu;
    endcase
    wb_res = wb_alu;
    case (wb_sel)
      2'd1:    wb_res = wb_imm;
      2'd2:    wb_res = wb_pc + PC_STEP;
      2'd3:    wb_res = wb_ram;
      default: wb_res = wb_alu;
    endcase
  end

  // Late stage re-presents last cycle's WB write for an RF without write-through.
  always_ff @(posedge clk) begin
    if (rst) begin
      late_valid <= 1'b0;
    end else begin
      late_valid <= (LATE_BYPASS != 0) && wb_regwrite && !flush;
    end
    late_dst <= wb_dst;
    late_res <= wb_res;
  end

  always_comb begin
    hit_a = 1'b1;
    fwd_a = rf_a;
    if (stage_hit(mem_regwrite, mem_dst, ex_ra))     fwd_a = mem_res;
    else if (stage_hit(wb_regwrite, wb_dst, ex_ra))  fwd_a = wb_res;
    else if (stage_hit(late_valid, late_dst, ex_ra)) fwd_a = late_res;
    else                                             hit_a = 1'b0;

    hit_b = 1'b1;
    fwd_b = rf_b;
    if (stage_hit(mem_regwrite, mem_dst, ex_rb))     fwd_b = mem_res;
    else if (stage_hit(wb_regwrite, wb_dst, ex_rb))  fwd_b = wb_res;
    else if (stage_hit(late_valid, late_dst, ex_rb)) fwd_b = late_res;
    else                                             hit_b = 1'b0;
  end

  assign x       = fwd_a;
  assign mem_din = fwd_b;
  assign y       = memwrite ? ext : (hit_b ? fwd_b : (alusrc ? ext : rf_b));
  assign fwd_evt = hit_a || (hit_b && !memwrite);

  assign hz = id_valid && ex_regwrite && ex_memtoreg && (ex_dst != '0) &&
              ((id_ra == ex_dst) || (id_rb == ex_dst));

  assign stall  = !rst && !flush && ((state == WAIT) || hz);
  assign bubble = stall;

  // First stall cycle is spent in IDLE; WAIT covers the remaining LOAD_LAT-1.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hz && MULTI_LAT) begin
            state <= WAIT;
            cnt   <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (fwd_evt && (fwd_count != '1)) fwd_count   <= fwd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized bench for fwd_hazard_unit: two configurations driven in lockstep
// and compared every cycle against a behavioural model.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid;
  logic [4:0]  id_ra, id_rb, ex_ra, ex_rb, ex_dst, mem_dst, wb_dst;
  logic        ex_regwrite, ex_memtoreg, alusrc, memwrite, mem_regwrite, wb_regwrite;
  logic [31:0] rf_a, rf_b, ext, mem_alu, mem_imm, mem_pc, wb_alu, wb_imm, wb_pc, wb_ram;
  logic [1:0]  mem_sel, wb_sel;

  logic [31:0] x_a, y_a, din_a, x_b, y_b, din_b;
  logic        stall_a, bubble_a, stall_b, bubble_b;
  logic [15:0] scnt_a, fcnt_a;
  logic [3:0]  scnt_b, fcnt_b;

  int checks = 0;
  int failures = 0;

  // Model state
  int          rem_a, rem_b, ms_a, mf_a, ms_b, mf_b;
  bit          late_v;
  logic [4:0]  late_d;
  logic [31:0] late_r;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.LOAD_LAT(1), .LATE_BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_dst(ex_dst), .rf_a(rf_a), .rf_b(rf_b), .ext(ext), .alusrc(alusrc), .memwrite(memwrite),
    .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_sel(mem_sel), .mem_alu(mem_alu),
    .mem_imm(mem_imm), .mem_pc(mem_pc), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
    .wb_sel(wb_sel), .wb_alu(wb_alu), .wb_imm(wb_imm), .wb_pc(wb_pc), .wb_ram(wb_ram),
    .x(x_a), .y(y_a), .mem_din(din_a), .stall(stall_a), .bubble(bubble_a),
    .stall_count(scnt_a), .fwd_count(fcnt_a));

  fwd_hazard_unit #(.LOAD_LAT(3), .LATE_BYPASS(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_dst(ex_dst), .rf_a(rf_a), .rf_b(rf_b), .ext(ext), .alusrc(alusrc), .memwrite(memwrite),
    .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_sel(mem_sel), .mem_alu(mem_alu),
    .mem_imm(mem_imm), .mem_pc(mem_pc), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
    .wb_sel(wb_sel), .wb_alu(wb_alu), .wb_imm(wb_imm), .wb_pc(wb_pc), .wb_ram(wb_ram),
    .x(x_b), .y(y_b), .mem_din(din_b), .stall(stall_b), .bubble(bubble_b),
    .stall_count(scnt_b), .fwd_count(fcnt_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_value();
    case (mem_sel)
      2'd1:    return mem_imm;
      2'd2:    return mem_pc + 32'd1;
      default: return mem_alu;
    endcase
  endfunction

  function automatic logic [31:0] wb_value();
    case (wb_sel)
      2'd1:    return wb_imm;
      2'd2:    return wb_pc + 32'd1;
      2'd3:    return wb_ram;
      default: return wb_alu;
    endcase
  endfunction

  // {hit, value}: newest producer of register s wins; r0 never forwards.
  function automatic logic [32:0] lookup(input logic [4:0] s, input bit lb, input logic [31:0] rf);
    if (s == 5'd0)                            return {1'b0, rf};
    if (mem_regwrite && mem_dst == s)         return {1'b1, mem_value()};
    if (wb_regwrite && wb_dst == s)           return {1'b1, wb_value()};
    if (lb && late_v && late_d == s)          return {1'b1, late_r};
    return {1'b0, rf};
  endfunction

  function automatic int sat_add(input int v, input bit inc, input int maxv);
    return (inc && v < maxv) ? v + 1 : v;
  endfunction

  task automatic check_cfg(input string nm, input bit lb, input int lat, input int maxv,
                           inout int rem, inout int ms, inout int mf,
                           input logic [31:0] x_o, input logic [31:0] y_o, input logic [31:0] d_o,
                           input logic st_o, input logic bb_o, input logic [31:0] sc_o,
                           input logic [31:0] fc_o, input bit hz);
    logic [32:0] fa, fb;
    logic [31:0] y_exp;
    bit st;
    fa = lookup(ex_ra, lb, rf_a);
    fb = lookup(ex_rb, lb, rf_b);
    y_exp = memwrite ? ext : (fb[32] ? fb[31:0] : (alusrc ? ext : rf_b));
    st = !rst && !flush && (rem > 0 || hz);
    check({nm, ".x"}, x_o, fa[31:0]);
    check({nm, ".y"}, y_o, y_exp);
    check({nm, ".mem_din"}, d_o, fb[31:0]);
    check({nm, ".stall"}, 32'(st_o), 32'(st));
    check({nm, ".bubble"}, 32'(bb_o), 32'(st));
    check({nm, ".stall_count"}, sc_o, 32'(ms));
    check({nm, ".fwd_count"}, fc_o, 32'(mf));
    if (rst) begin
      rem = 0; ms = 0; mf = 0;
    end else begin
      if (flush)        rem = 0;
      else if (rem > 0) rem = rem - 1;
      else if (hz)      rem = lat - 1;
      ms = sat_add(ms, st, maxv);
      mf = sat_add(mf, fa[32] || (fb[32] && !memwrite), maxv);
    end
  endtask

  // Check the current cycle, advance the model, then move to the next drive point.
  task automatic step();
    bit hz;
    #1;
    hz = id_valid && ex_regwrite && ex_memtoreg && ex_dst != 5'd0 &&
         (id_ra == ex_dst || id_rb == ex_dst);
    check_cfg("a", 1'b1, 1, 65535, rem_a, ms_a, mf_a, x_a, y_a, din_a, stall_a, bubble_a,
              32'(scnt_a), 32'(fcnt_a), hz);
    check_cfg("b", 1'b0, 3, 15, rem_b, ms_b, mf_b, x_b, y_b, din_b, stall_b, bubble_b,
              32'(scnt_b), 32'(fcnt_b), hz);
    late_v = !rst && !flush && wb_regwrite;
    late_d = wb_dst;
    late_r = wb_value();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {flush, id_valid, ex_regwrite, ex_memtoreg, alusrc, memwrite, mem_regwrite, wb_regwrite} = '0;
    {id_ra, id_rb, ex_ra, ex_rb, ex_dst, mem_dst, wb_dst} = '0;
    {rf_a, rf_b, ext, mem_alu, mem_imm, mem_pc, wb_alu, wb_imm, wb_pc, wb_ram} = '0;
    mem_sel = 2'd0;
    wb_sel  = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    rst          = ($urandom_range(0, 299) == 0);
    flush        = ($urandom_range(0, 11) == 0);
    id_valid     = ($urandom_range(0, 3) != 0);
    id_ra        = 5'($urandom_range(0, 3));
    id_rb        = 5'($urandom_range(0, 3));
    ex_ra        = 5'($urandom_range(0, 3));
    ex_rb        = 5'($urandom_range(0, 3));
    ex_dst       = 5'($urandom_range(0, 3));
    ex_regwrite  = 1'($urandom);
    ex_memtoreg  = ($urandom_range(0, 2) == 0);
    alusrc       = 1'($urandom);
    memwrite     = ($urandom_range(0, 3) == 0);
    mem_regwrite = 1'($urandom);
    mem_dst      = 5'($urandom_range(0, 3));
    mem_sel      = 2'($urandom);
    wb_regwrite  = 1'($urandom);
    wb_dst       = 5'($urandom_range(0, 3));
    wb_sel       = 2'($urandom);
    {rf_a, rf_b, ext} = {$urandom, $urandom, $urandom};
    {mem_alu, mem_imm, mem_pc} = {$urandom, $urandom, $urandom};
    {wb_alu, wb_imm, wb_pc, wb_ram} = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    {rem_a, rem_b, ms_a, mf_a, ms_b, mf_b} = '0;
    late_v = 1'b0; late_d = '0; late_r = '0;
    do_reset();

    // ALU result in MEM beats the older one in WB
    mem_regwrite = 1'b1; mem_dst = 5'd3; mem_alu = 32'h11;
    wb_regwrite = 1'b1; wb_dst = 5'd3; wb_alu = 32'h22; ex_ra = 5'd3;
    #1 check("dir.mem_over_wb", x_a, 32'h11);
    step();
    clear_inputs();
    #1 check("dir.fwd_count_1", 32'(fcnt_a), 32'd1);
    step();

    // r0 never forwards
    mem_regwrite = 1'b1; mem_dst = 5'd0; ex_ra = 5'd0; rf_a = 32'h5;
    #1 check("dir.r0", x_a, 32'h5);
    step();

    // jal link and lui values from MEM
    clear_inputs();
    mem_regwrite = 1'b1; mem_dst = 5'd31; mem_sel = 2'd2; mem_pc = 32'h40;
    ex_rb = 5'd31; alusrc = 1'b1; ext = 32'h7;
    #1 check("dir.jal_y", y_a, 32'h41);
    check("dir.jal_din", din_a, 32'h41);
    step();
    mem_sel = 2'd1; mem_imm = 32'hABCD0000;
    #1 check("dir.lui_y", y_a, 32'hABCD0000);
    step();

    // Load-use: one stall in config a, three in config b
    clear_inputs();
    do_reset();
    ex_regwrite = 1'b1; ex_memtoreg = 1'b1; ex_dst = 5'd4; id_valid = 1'b1; id_ra = 5'd4;
    #1 check("dir.lu_stall_a", 32'(stall_a), 32'd1);
    step();
    clear_inputs();
    wb_regwrite = 1'b1; wb_dst = 5'd4; wb_sel = 2'd3; wb_ram = 32'h99; ex_ra = 5'd4;
    #1 check("dir.lu_nostall_a", 32'(stall_a), 32'd0);
    check("dir.lu_ram_x", x_a, 32'h99);
    check("dir.lu_stall_b2", 32'(stall_b), 32'd1);
    step();
    clear_inputs();
    step();
    #1 check("dir.lu_done_b", 32'(stall_b), 32'd0);
    check("dir.lu_count_b", 32'(scnt_b), 32'd3);
    step();

    // Late bypass one cycle after WB
    wb_regwrite = 1'b1; wb_dst = 5'd7; wb_alu = 32'h55;
    step();
    clear_inputs();
    ex_ra = 5'd7; rf_a = 32'h1;
    #1 check("dir.late_a", x_a, 32'h55);
    check("dir.late_off_b", x_b, 32'h1);
    step();

    // Flush on the second stall cycle of config b
    clear_inputs();
    ex_regwrite = 1'b1; ex_memtoreg = 1'b1; ex_dst = 5'd2; id_valid = 1'b1; id_rb = 5'd2;
    step();
    clear_inputs();
    flush = 1'b1;
    #1 check("dir.flush_b", 32'(stall_b), 32'd0);
    step();
    flush = 1'b0;
    #1 check("dir.post_flush_b", 32'(stall_b), 32'd0);
    step();

    // Reset mid-stall
    ex_regwrite = 1'b1; ex_memtoreg = 1'b1; ex_dst = 5'd2; id_valid = 1'b1; id_rb = 5'd2;
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 check("dir.rst_stall_b", 32'(stall_b), 32'd0);
    check("dir.rst_scnt_b", 32'(scnt_b), 32'd0);
    check("dir.rst_fcnt_a", 32'(fcnt_a), 32'd0);
    step();

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use hazard controller for the 5-stage pipeline.
- Forwards the ALU operands and the store data into EX from the MEM stage, the WB stage and an optional registered late-bypass stage.
- Stalls IF/ID and injects a bubble into EX for load-use hazards, with a configurable load latency.
- Keeps saturating stall and forward event counters for performance debug.

Parameters:
DW, 32, data/PC width
AW, 5, register-address width; address 0 is hardwired zero
LOAD_LAT, 1, load-data latency in cycles (1..4); stall length on a load-use hazard
PC_INC, 1, PC increment for jal link value (1 = word-addressed PC)
LATE_BYPASS, 1, 1 enables the registered third forwarding stage
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush (branch/interrupt redirect)
id_valid  in  1  ID holds a valid instruction
id_ra, id_rb  in  AW  ID source registers
ex_ra, ex_rb  in  AW  EX source registers
ex_regwrite, ex_memtoreg  in  1  EX instruction writes a register / is a load
ex_dst  in  AW  EX destination register
rf_a, rf_b, ext  in  DW  register-file operands and extended immediate for EX
alusrc, memwrite  in  1  EX operand-B select and store flag
mem_regwrite  in  1  MEM instruction writes a register
mem_dst  in  AW  MEM destination register
mem_sel  in  2  MEM result select: 0 ALU, 1 imm (lui), 2 PC+PC_INC (jal), 3 reserved (treated as ALU)
mem_alu, mem_imm, mem_pc  in  DW  MEM stage values
wb_regwrite  in  1  WB instruction writes a register
wb_dst  in  AW  WB destination register
wb_sel  in  2  WB select: 0 ALU, 1 imm, 2 PC+PC_INC, 3 RAM
wb_alu, wb_imm, wb_pc, wb_ram  in  DW  WB stage values
x, y  out  DW  ALU operands
mem_din  out  DW  store data
stall  out  1  hold PC and IF/ID
bubble  out  1  convert the next EX entry into a NOP
stall_count, fwd_count  out  CNT_W  performance counters

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Result values:
  - mem_res = mem_imm / mem_pc+PC_INC / mem_alu, selected by mem_sel.
  - wb_res = wb_imm / wb_pc+PC_INC / wb_ram / wb_alu, selected by wb_sel.
  - All additions are mod 2^DW.
- Stage match: a stage matches source s when that stage's regwrite=1, its dst==s and s!=0.
- Forwarding priority: MEM > WB > LATE > register file.
- LATE stage (LATE_BYPASS=1):
  - Registers (wb_regwrite, wb_dst, wb_res) every cycle.
  - Covers a register file that does not write-through within the same cycle.
  - With LATE_BYPASS=0 the LATE stage never matches.
- Operand outputs:
  - x = forwarded value for ex_ra.
  - y = ext if memwrite=1; otherwise the forwarded value for ex_rb if any stage matches; otherwise ext if alusrc=1, else rf_b.
  - mem_din = forwarded value for ex_rb, else rf_b.
  - x, y and mem_din are combinational, with zero latency.
- Hazard detection:
  - hz = id_valid & ex_regwrite & ex_memtoreg & ex_dst!=0 & (id_ra==ex_dst | id_rb==ex_dst).
- FSM states:
  - IDLE: stall = bubble = hz. If hz and LOAD_LAT>1: go to WAIT with cnt=LOAD_LAT-2.
  - WAIT: stall = bubble = 1. If cnt==0 go to IDLE, else cnt decrements.
  - Total stall length is exactly LOAD_LAT cycles per hazard.
- flush has priority over everything:
  - stall=bubble=0 combinationally that cycle.
  - FSM goes to IDLE and the LATE stage is invalidated.
  - The counters are not affected.
- rst (registered, takes effect on the next edge):
  - FSM=IDLE, cnt=0, LATE invalid, stall_count=fwd_count=0.
  - While rst=1: stall=bubble=0.
- Counters:
  - stall_count +1 per cycle with stall=1.
  - fwd_count +1 per cycle in which x or y takes a forwarded (non-RF) value; the memwrite/alusrc ext path does not count.
  - Both saturate at 2^CNT_W-1.
- Simultaneous events:
  - A hazard detected in the same cycle as flush is discarded.
  - Overlapping hazards cannot occur, because EX receives a bubble during a stall.

Test Plan:
1. Back-to-back ALU write then use: MEM has dst=3, alu=0x11; WB has dst=3, alu=0x22; ex_ra=3 → x=0x11; fwd_count 0→1.
2. Zero register: mem_dst=0 with mem_regwrite=1, ex_ra=0, rf_a=0x5 → x=0x5; no forwarding is counted.
3. jal/lui select: mem_sel=2, mem_pc=0x40, PC_INC=1, ex_rb=31=mem_dst, alusrc=1 → y=0x41, mem_din=0x41; mem_sel=1, mem_imm=0xABCD0000 → y=0xABCD0000.
4. Load-use: LOAD_LAT=1, ex load dst=4, id_ra=4 → stall=bubble=1 for exactly 1 cycle; next cycle wb_sel=3, wb_ram=0x99 → x=0x99. With LOAD_LAT=3 → stall for exactly 3 cycles; stall_count=3.
5. Late bypass: WB writes r7=0x55, one cycle later no stage matches and ex_ra=7 → x=0x55; with LATE_BYPASS=0 → x=rf_a.
6. Flush in WAIT (LOAD_LAT=3, 2nd stall cycle) → stall=0 the same cycle, FSM returns to IDLE; rst mid-stall → next cycle stall=0 and both counters=0.
